// File: rtl/otter_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage OTTER pipeline.
// Optional perf counters (STALL_CNT/FLUSH_CNT) built when HAZ_PERF_CNT_EN is defined.
module otter_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  DE_RS1,
    input  logic [4:0]  DE_RS2,
    input  logic        DE_USES_RS1,
    input  logic        DE_USES_RS2,
    input  logic [4:0]  EX_RS1,
    input  logic [4:0]  EX_RS2,
    input  logic [4:0]  EX_RD,
    input  logic        EX_REG_WRITE,
    input  logic        EX_MEM_READ,
    input  logic        EX_BRANCH_TAKEN,
    input  logic [4:0]  MEM_RD,
    input  logic        MEM_REG_WRITE,
    input  logic [4:0]  WB_RD,
    input  logic        WB_REG_WRITE,
    input  logic        DMEM_REQ,
    input  logic        DMEM_READY,
    input  logic        MEM_ERR,
    output logic        PC_EN,
    output logic        FE_DE_EN,
    output logic        DE_EX_EN,
    output logic        EX_MEM_EN,
    output logic        MEM_WB_EN,
    output logic        FE_DE_FLUSH,
    output logic        DE_EX_FLUSH,
    output logic        MEM_WB_FLUSH,
    output logic [1:0]  FWD_A_SEL,
    output logic [1:0]  FWD_B_SEL,
    output logic        HALTED,
    output logic        TIMEOUT,
    output logic [31:0] STALL_CNT,
    output logic [31:0] FLUSH_CNT
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               timeout_q;
    logic               mem_wait;
    logic               load_use;
    logic               wait_last;

    assign mem_wait  = DMEM_REQ && !DMEM_READY;
    assign wait_last = (state == MEM_WAIT) && (wait_cnt == CNT_W'(MAX_WAIT - 1));
    assign load_use  = EX_MEM_READ && EX_REG_WRITE && (EX_RD != 5'd0) &&
                       ((DE_USES_RS1 && (DE_RS1 == EX_RD)) ||
                        (DE_USES_RS2 && (DE_RS2 == EX_RD)));

    assign HALTED  = (state == HALT) && !RST;
    assign TIMEOUT = timeout_q && !RST;

    // wait_cnt counts MEM_WAIT cycles only, so MEM_WAIT lasts at most MAX_WAIT cycles
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                RUN, MEM_WAIT: begin
                    if (MEM_ERR) begin
                        state <= HALT;
                    end else if (mem_wait) begin
                        if (wait_last) begin
                            state     <= HALT;
                            timeout_q <= 1'b1;
                        end else begin
                            state <= MEM_WAIT;
                            if (state == MEM_WAIT)
                                wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end
                end
                HALT:    state <= HALT;
                default: state <= RUN;
            endcase
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] mem_rd, input logic mem_we,
                                           input logic [4:0] wb_rd,  input logic wb_we);
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs))
            return 2'b01;
        else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        PC_EN        = 1'b1;
        FE_DE_EN     = 1'b1;
        DE_EX_EN     = 1'b1;
        EX_MEM_EN    = 1'b1;
        MEM_WB_EN    = 1'b1;
        FE_DE_FLUSH  = 1'b0;
        DE_EX_FLUSH  = 1'b0;
        MEM_WB_FLUSH = 1'b0;
        FWD_A_SEL    = fwd_sel(EX_RS1, MEM_RD, MEM_REG_WRITE, WB_RD, WB_REG_WRITE);
        FWD_B_SEL    = fwd_sel(EX_RS2, MEM_RD, MEM_REG_WRITE, WB_RD, WB_REG_WRITE);
        if (RST) begin
            FWD_A_SEL = 2'b00;
            FWD_B_SEL = 2'b00;
        end else if (state == HALT) begin
            {PC_EN, FE_DE_EN, DE_EX_EN, EX_MEM_EN, MEM_WB_EN} = 5'b0;
            FWD_A_SEL = 2'b00;
            FWD_B_SEL = 2'b00;
        end else if (MEM_ERR) begin
            {PC_EN, FE_DE_EN, DE_EX_EN, EX_MEM_EN, MEM_WB_EN} = 5'b0;
        end else if (mem_wait) begin
            // WB retires its instruction once, then bubbles drain behind it
            {PC_EN, FE_DE_EN, DE_EX_EN, EX_MEM_EN} = 4'b0;
            MEM_WB_FLUSH = 1'b1;
        end else if (EX_BRANCH_TAKEN) begin
            FE_DE_FLUSH = 1'b1;
            DE_EX_FLUSH = 1'b1;
        end else if (load_use) begin
            PC_EN       = 1'b0;
            FE_DE_EN    = 1'b0;
            DE_EX_FLUSH = 1'b1;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    // FE_DE_FLUSH is raised only by a taken-branch redirect
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!PC_EN && (state != HALT))
                stall_cnt <= stall_cnt + 32'd1;
            if (FE_DE_FLUSH)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign STALL_CNT = stall_cnt;
    assign FLUSH_CNT = flush_cnt;
`else
    assign STALL_CNT = '0;
    assign FLUSH_CNT = '0;
`endif

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Directed scoreboard bench for otter_hazard_ctrl (MAX_WAIT=4).
module tb_otter_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  DE_RS1, DE_RS2, EX_RS1, EX_RS2, EX_RD, MEM_RD, WB_RD;
    logic        DE_USES_RS1, DE_USES_RS2, EX_REG_WRITE, EX_MEM_READ, EX_BRANCH_TAKEN;
    logic        MEM_REG_WRITE, WB_REG_WRITE, DMEM_REQ, DMEM_READY, MEM_ERR;
    logic        PC_EN, FE_DE_EN, DE_EX_EN, EX_MEM_EN, MEM_WB_EN;
    logic        FE_DE_FLUSH, DE_EX_FLUSH, MEM_WB_FLUSH;
    logic [1:0]  FWD_A_SEL, FWD_B_SEL;
    logic        HALTED, TIMEOUT;
    logic [31:0] STALL_CNT, FLUSH_CNT;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [13:0] v;
    } exp_t;
    exp_t sb[$];

    otter_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .DE_RS1(DE_RS1), .DE_RS2(DE_RS2), .DE_USES_RS1(DE_USES_RS1), .DE_USES_RS2(DE_USES_RS2),
        .EX_RS1(EX_RS1), .EX_RS2(EX_RS2), .EX_RD(EX_RD), .EX_REG_WRITE(EX_REG_WRITE),
        .EX_MEM_READ(EX_MEM_READ), .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN),
        .MEM_RD(MEM_RD), .MEM_REG_WRITE(MEM_REG_WRITE), .WB_RD(WB_RD), .WB_REG_WRITE(WB_REG_WRITE),
        .DMEM_REQ(DMEM_REQ), .DMEM_READY(DMEM_READY), .MEM_ERR(MEM_ERR),
        .PC_EN(PC_EN), .FE_DE_EN(FE_DE_EN), .DE_EX_EN(DE_EX_EN), .EX_MEM_EN(EX_MEM_EN),
        .MEM_WB_EN(MEM_WB_EN), .FE_DE_FLUSH(FE_DE_FLUSH), .DE_EX_FLUSH(DE_EX_FLUSH),
        .MEM_WB_FLUSH(MEM_WB_FLUSH), .FWD_A_SEL(FWD_A_SEL), .FWD_B_SEL(FWD_B_SEL),
        .HALTED(HALTED), .TIMEOUT(TIMEOUT), .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic clr_inputs();
        {DE_RS1, DE_RS2, EX_RS1, EX_RS2, EX_RD, MEM_RD, WB_RD} = '0;
        {DE_USES_RS1, DE_USES_RS2, EX_REG_WRITE, EX_MEM_READ, EX_BRANCH_TAKEN} = '0;
        {MEM_REG_WRITE, WB_REG_WRITE, DMEM_REQ, DMEM_READY, MEM_ERR} = '0;
    endtask

    // en = {PC,FE_DE,DE_EX,EX_MEM,MEM_WB}, fl = {FE_DE,DE_EX,MEM_WB}
    task automatic step(input string tag, input logic [4:0] en, input logic [2:0] fl,
                        input logic [1:0] fa, input logic [1:0] fb, input logic h, input logic t);
        exp_t e;
        logic [13:0] obs;
        e.tag = tag;
        e.v   = {en, fl, fa, fb, h, t};
        sb.push_back(e);
        #1;
        obs = {PC_EN, FE_DE_EN, DE_EX_EN, EX_MEM_EN, MEM_WB_EN, FE_DE_FLUSH, DE_EX_FLUSH,
               MEM_WB_FLUSH, FWD_A_SEL, FWD_B_SEL, HALTED, TIMEOUT};
        e = sb.pop_front();
        n_assert++;
        assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", e.tag, obs, e.v);
        end
        @(negedge CLK);
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] es, input logic [31:0] ef);
        logic [31:0] xs, xf;
`ifdef HAZ_PERF_CNT_EN
        xs = es;
        xf = ef;
`else
        xs = 32'd0;
        xf = 32'd0;
`endif
        #1;
        n_assert++;
        assert ({STALL_CNT, FLUSH_CNT} === {xs, xf}) else begin
            n_fail++;
            $error("FAIL %s: observed stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   tag, STALL_CNT, FLUSH_CNT, xs, xf);
        end
    endtask

    initial begin
        clr_inputs();
        RST = 1'b1;
        EX_MEM_READ = 1; EX_REG_WRITE = 1; EX_RD = 5; DE_USES_RS1 = 1; DE_RS1 = 5;
        MEM_REG_WRITE = 1; MEM_RD = 3; EX_RS1 = 3;
        @(negedge CLK);
        step("reset_outputs", 5'b11111, 3'b000, 2'b00, 2'b00, 0, 0);

        RST = 1'b0;
        clr_inputs();
        chk_cnt("reset_counters", 0, 0);
        step("idle", 5'b11111, 3'b000, 2'b00, 2'b00, 0, 0);

        EX_MEM_READ = 1; EX_REG_WRITE = 1; EX_RD = 5; DE_USES_RS1 = 1; DE_RS1 = 5;
        step("load_use_rs1", 5'b00111, 3'b010, 2'b00, 2'b00, 0, 0);
        clr_inputs();
        step("load_use_release", 5'b11111, 3'b000, 2'b00, 2'b00, 0, 0);

        EX_MEM_READ = 1; EX_REG_WRITE = 1; EX_RD = 0; DE_USES_RS2 = 1; DE_RS2 = 0;
        step("load_use_x0", 5'b11111, 3'b000, 2'b00, 2'b00, 0, 0);
        clr_inputs();

        MEM_RD = 7; MEM_REG_WRITE = 1; WB_RD = 7; WB_REG_WRITE = 1; EX_RS1 = 7; EX_RS2 = 3;
        step("fwd_mem_wins", 5'b11111, 3'b000, 2'b01, 2'b00, 0, 0);
        MEM_RD = 9; EX_RS2 = 7;
        step("fwd_wb_both", 5'b11111, 3'b000, 2'b10, 2'b10, 0, 0);
        MEM_RD = 0; WB_RD = 0; EX_RS1 = 0; EX_RS2 = 0;
        step("fwd_x0", 5'b11111, 3'b000, 2'b00, 2'b00, 0, 0);
        clr_inputs();

        EX_BRANCH_TAKEN = 1;
        EX_MEM_READ = 1; EX_REG_WRITE = 1; EX_RD = 5; DE_USES_RS2 = 1; DE_RS2 = 5;
        step("branch_over_load_use", 5'b11111, 3'b110, 2'b00, 2'b00, 0, 0);
        clr_inputs();

        DMEM_REQ = 1; DMEM_READY = 1;
        step("zero_wait", 5'b11111, 3'b000, 2'b00, 2'b00, 0, 0);
        DMEM_READY = 0;
        step("mem_wait_1", 5'b00001, 3'b001, 2'b00, 2'b00, 0, 0);
        EX_BRANCH_TAKEN = 1;
        step("mem_wait_2_branch_ignored", 5'b00001, 3'b001, 2'b00, 2'b00, 0, 0);
        step("mem_wait_3", 5'b00001, 3'b001, 2'b00, 2'b00, 0, 0);
        DMEM_READY = 1;
        step("mem_ready_redirect", 5'b11111, 3'b110, 2'b00, 2'b00, 0, 0);
        clr_inputs();
        step("run_after_wait", 5'b11111, 3'b000, 2'b00, 2'b00, 0, 0);

        DMEM_REQ = 1;
        step("to_run_stall", 5'b00001, 3'b001, 2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 4; i++)
            step($sformatf("to_wait_%0d", i), 5'b00001, 3'b001, 2'b00, 2'b00, 0, 0);
        MEM_RD = 7; MEM_REG_WRITE = 1; EX_RS1 = 7;
        chk_cnt("counters_at_timeout", 9, 2);
        step("timeout_halt", 5'b00000, 3'b000, 2'b00, 2'b00, 1, 1);
        clr_inputs();
        EX_BRANCH_TAKEN = 1;
        step("halt_sticky", 5'b00000, 3'b000, 2'b00, 2'b00, 1, 1);
        clr_inputs();

        RST = 1'b1;
        step("reset_from_halt", 5'b11111, 3'b000, 2'b00, 2'b00, 0, 0);
        RST = 1'b0;
        chk_cnt("counters_cleared", 0, 0);
        step("idle_after_reset", 5'b11111, 3'b000, 2'b00, 2'b00, 0, 0);

        DMEM_REQ = 1;
        step("err_pre_wait", 5'b00001, 3'b001, 2'b00, 2'b00, 0, 0);
        MEM_ERR = 1;
        step("mem_err_in_wait", 5'b00000, 3'b000, 2'b00, 2'b00, 0, 0);
        clr_inputs();
        step("err_halt", 5'b00000, 3'b000, 2'b00, 2'b00, 1, 0);
        step("err_halt_hold", 5'b00000, 3'b000, 2'b00, 2'b00, 1, 0);
        chk_cnt("counters_frozen_in_halt", 2, 0);

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/otter_hazard_ctrl.md
Name: otter_hazard_ctrl

Overview:
Central stall/flush/forwarding controller for the 5-stage OTTER pipeline (FE, DE, EX, MEM, WB).
- Drives the PC enable, plus an enable and a flush (bubble) for each pipeline register.
- Detects load-use hazards, redirects on taken branches, and waits on a multi-cycle data-memory handshake with timeout.
- Halts the core on a memory error.
- Drives the EX-stage operand forwarding selects.

Parameters:
MAX_WAIT, 16, cycles allowed in MEM_WAIT before a timeout halt (legal range 1..255)
CNT_W, 8, width of the wait counter

Ports:
CLK  in  1  clock
RST  in  1  reset
DE_RS1  in  5  rs1 of the instruction in DE
DE_RS2  in  5  rs2 of the instruction in DE
DE_USES_RS1  in  1  DE instruction reads rs1
DE_USES_RS2  in  1  DE instruction reads rs2
EX_RS1  in  5  rs1 of the instruction in EX
EX_RS2  in  5  rs2 of the instruction in EX
EX_RD  in  5  destination register of the EX instruction
EX_REG_WRITE  in  1  EX instruction writes the register file
EX_MEM_READ  in  1  EX instruction is a load
EX_BRANCH_TAKEN  in  1  EX resolved a taken branch or jump
MEM_RD  in  5  destination register of the MEM instruction
MEM_REG_WRITE  in  1  MEM instruction writes the register file
WB_RD  in  5  destination register of the WB instruction
WB_REG_WRITE  in  1  WB instruction writes the register file
DMEM_REQ  in  1  MEM stage is accessing data memory
DMEM_READY  in  1  data-memory access completes this cycle
MEM_ERR  in  1  misaligned or out-of-bounds access in MEM
PC_EN, FE_DE_EN, DE_EX_EN, EX_MEM_EN, MEM_WB_EN  out  1 each  register load enables
FE_DE_FLUSH, DE_EX_FLUSH, MEM_WB_FLUSH  out  1 each  load a bubble (all zero) instead of data
FWD_A_SEL  out  2  EX source-A forward: 00 register file, 01 EX_MEM.ALU_RESULT, 10 WB data
FWD_B_SEL  out  2  EX source-B forward, same encoding as FWD_A_SEL
HALTED  out  1  core stopped
TIMEOUT  out  1  halt was caused by a wait timeout
STALL_CNT  out  32  stall cycle count (optional feature)
FLUSH_CNT  out  32  flush event count (optional feature)

Behaviour:
- Clock and reset: CLK is the clock. RST is synchronous and active-high.
  - Reset puts the FSM in RUN, clears the wait counter, and clears HALTED, TIMEOUT and the counters.
  - During reset and in the reset cycle: all *_EN=1, all *_FLUSH=0, FWD_*=00.
- FSM states: RUN, MEM_WAIT, HALT. Outputs are Mealy: decoded from state and inputs within the same cycle.
- Priority within a cycle (highest first): MEM_ERR > memory wait > taken branch > load-use.
- MEM_ERR=1 in RUN or MEM_WAIT:
  - This cycle: all *_EN=0.
  - Next state HALT.
- HALT:
  - All *_EN=0, all *_FLUSH=0, HALTED=1.
  - Only RST exits HALT.
- Memory wait (DMEM_REQ=1 and DMEM_READY=0) in RUN or MEM_WAIT:
  - PC_EN, FE_DE_EN, DE_EX_EN and EX_MEM_EN are 0.
  - MEM_WB_EN=1 with MEM_WB_FLUSH=1, so the WB instruction retires once and bubbles follow.
  - Next state MEM_WAIT. The wait counter increments on each MEM_WAIT cycle.
  - When the counter reaches MAX_WAIT-1 while the wait persists: next state HALT, TIMEOUT=1.
- DMEM_READY=1 in MEM_WAIT: normal enables this cycle, counter cleared, next state RUN.
- DMEM_READY=1 in the request cycle itself: zero-wait access, no stall.
- EX_BRANCH_TAKEN=1 while MEM_WAIT is stalling: ignored. EX is held, so the redirect is acted on in the cycle the stall lifts.
- Taken branch (RUN, no wait):
  - PC_EN=1 (PC loads the target).
  - FE_DE_FLUSH=1 and DE_EX_FLUSH=1, discarding two wrong-path instructions.
  - Suppresses any simultaneous load-use stall.
- Load-use hazard:
  - Condition: EX_MEM_READ, EX_REG_WRITE, EX_RD!=0, and (DE_USES_RS1 and DE_RS1==EX_RD, or DE_USES_RS2 and DE_RS2==EX_RD).
  - Response: PC_EN=0, FE_DE_EN=0, DE_EX_FLUSH=1, for exactly one cycle.
  - The next cycle resolves it through WB/MEM forwarding.
- Forwarding (combinational; independent of state except HALT, where it is 00), shown for source A:
  - 01 if MEM_REG_WRITE, MEM_RD!=0 and MEM_RD==EX_RS1.
  - Otherwise 10 if WB_REG_WRITE, WB_RD!=0 and WB_RD==EX_RS1.
  - Otherwise 00.
  - Source B is identical, using EX_RS2.
  - MEM stage wins over WB. x0 is never forwarded.
- All *_FLUSH outputs are only asserted together with the matching *_EN=1.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined:
  - STALL_CNT increments on every cycle with PC_EN=0 outside HALT.
  - FLUSH_CNT increments on every taken-branch flush.
  - Both are 32-bit, wrap at 2^32, and are cleared by RST.
- Undefined: STALL_CNT and FLUSH_CNT are tied to 0 and no counter flops exist.

Test Plan:
Load-use: EX lw x5 (EX_MEM_READ=1, EX_RD=5); DE add rs1=5 -> one cycle PC_EN=0, FE_DE_EN=0, DE_EX_FLUSH=1; next cycle all enables 1.
Forwarding: MEM_RD=7/MEM_REG_WRITE=1 and WB_RD=7/WB_REG_WRITE=1 with EX_RS1=7 -> FWD_A_SEL=01. Same with rd=0 -> 00.
Branch and load-use together: EX_BRANCH_TAKEN=1 plus a load-use hazard -> PC_EN=1, FE_DE_FLUSH=1, DE_EX_FLUSH=1, no stall.
Memory wait: DMEM_REQ=1, DMEM_READY low for 3 cycles -> 3 stall cycles with MEM_WB_FLUSH=1; on the ready cycle, state returns to RUN.
Timeout: MAX_WAIT=4, DMEM_READY never asserted -> HALTED=1 and TIMEOUT=1 after 4 wait cycles; RST clears both.
Error: MEM_ERR=1 during MEM_WAIT -> all enables 0, HALTED=1 next cycle; with HAZ_PERF_CNT_EN defined, STALL_CNT stops incrementing.
